// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared widths, FSM state encoding and preset branch targets
package pc_ctrl_pkg;
  localparam int PC_W = 10;
  localparam int IDX_W = 5;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [PC_W-1:0] DEFAULT_TARGETS [2**IDX_W] = '{
    0: 10'h040, 1: 10'h03D, 2: 10'h034, 3: 10'h053,
    4: 10'h053, 5: 10'h053, 6: 10'h04A, 7: 10'h065,
    default: '0
  };
endpackage

// File: rtl/branch_target_table.sv
// branch_target_table: async-reset target register file, one write port, two read ports; BRANCH_TABLE_PRESET_EN presets entries from DEFAULT_TARGETS
module branch_target_table
  import pc_ctrl_pkg::*;
#(
  parameter int PW = PC_W,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  logic [PW-1:0] wr_data,
  input  logic [IW-1:0] rd_idx_a,
  output logic [PW-1:0] rd_data_a,
  input  logic [IW-1:0] rd_idx_b,
  output logic [PW-1:0] rd_data_b
);
  logic [PW-1:0] mem [2**IW];
  // reset to preset or zero contents; otherwise accept one write per edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**IW; i++)
`ifdef BRANCH_TABLE_PRESET_EN
        mem[i] <= DEFAULT_TARGETS[i];
`else
        mem[i] <= '0;
`endif
    else if (we)
      mem[wr_idx] <= wr_data;
  assign rd_data_a = mem[rd_idx_a];
  assign rd_data_b = mem[rd_idx_b];
endmodule

// File: rtl/pc_branch_ctrl.sv
// pc_branch_ctrl: PC sequencer with runtime-loadable branch-target table (see branch_target_table for BRANCH_TABLE_PRESET_EN)
module pc_branch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PW = PC_W,
  parameter int IW = IDX_W,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_en,
  input  logic          start,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [IW-1:0] wr_idx,
  input  logic [PW-1:0] wr_target,
  input  logic          branch_en,
  input  logic [IW-1:0] branch_idx,
  input  logic          halt,
  input  logic          stall,
  output logic [PW-1:0] pc,
  output logic [PW-1:0] target,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] cycles
);
  state_t state;
  logic [PW-1:0] br_tgt;
  assign wr_ready = state == LOAD;
  assign running = state == RUN;
  assign done = state == DONE;
  branch_target_table #(.PW(PW), .IW(IW)) u_tbl (
    .clk(clk),
    .rst_n(rst_n),
    .we(wr_valid && wr_ready),
    .wr_idx(wr_idx),
    .wr_data(wr_target),
    .rd_idx_a(branch_idx),
    .rd_data_a(br_tgt),
    .rd_idx_b(branch_idx),
    .rd_data_b(target)
  );
  // FSM with PC select (stall > halt > branch > increment) and saturating run counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= '0;
      cycles <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (load_en) state <= LOAD;
          else if (start) begin
            state <= RUN;
            pc <= '0;
            cycles <= '0;
          end
        LOAD:
          if (!load_en) state <= IDLE;
        RUN: begin
          cycles <= &cycles ? cycles : cycles + CW'(1);
          if (!stall) begin
            if (halt) state <= DONE;
            else pc <= branch_en ? br_tgt : pc + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
endmodule
